adder_switch_cfg_seq: RTL and testbench
=======================================

Name: adder_switch_cfg_seq

Overview:
- Configuration sequencer for a row of NUM_AS adder switches in the reduction network.
- Holds a small config memory. Each entry is one "fold": per-switch {add_en, cmd[2:0], sel}.
- On start, issues entries 0..num_folds-1 on consecutive unstalled cycles, driving the switches' valid, add-enable, command and select inputs.
- After the last fold, waits for the adder pipeline to drain, then pulses done.

Parameters:
- NUM_AS, 4, number of adder switches driven.
- SEL_IN, 2, select width per switch.
- DEPTH, 16, config memory entries.
- ADDR_W, 4, address width (clog2 DEPTH).
- ADD_LAT, 1, adder pipeline latency in cycles.
- ENT_W, NUM_AS*(4+SEL_IN), entry width. Per switch k, bits [k*(4+SEL_IN) +: 4+SEL_IN] = {add_en, cmd[2:0], sel}.

Ports:
- CLK  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_cfg_wr_en  in  1  config write strobe.
- i_cfg_wr_addr  in  ADDR_W  write address.
- i_cfg_wr_data  in  ENT_W  entry data.
- i_start  in  1  start sequence.
- i_num_folds  in  ADDR_W+1  folds to issue; legal range 1..DEPTH.
- i_stall  in  1  downstream backpressure.
- o_valid  out  1  to switch i_valid.
- o_add_en  out  NUM_AS  per-switch add enable.
- o_cmd  out  3*NUM_AS  per-switch command.
- o_sel  out  SEL_IN*NUM_AS  per-switch select.
- o_fold_idx  out  ADDR_W  index of the entry currently on the outputs.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky error flag.

Behaviour:
- Reset: rst is synchronous, active-high; clock CLK.
  - Every output resets to 0 and the FSM returns to IDLE. This applies mid-sequence too: the sequence is aborted and no done pulse is issued.
  - Memory contents are not reset.
- Outputs: all outputs are registered.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - Writes are accepted: mem[addr] <= data at the edge.
  - i_start with 1<=i_num_folds<=DEPTH: latch num_folds, clear o_err, go to ISSUE.
    - If i_stall=0 on that same edge, load entry 0 onto the outputs with o_valid=1 and ptr=1.
    - If i_stall=1, o_valid=0 and ptr=0.
  - First o_valid is therefore high in the cycle right after i_start is sampled.
  - i_start with num_folds 0 or >DEPTH: set o_err and stay in IDLE.
- ISSUE:
  - Each edge with i_stall=0: outputs <= mem[ptr], o_valid=1, o_fold_idx=ptr, ptr++.
  - Each edge with i_stall=1: o_valid=0; add_en/cmd/sel/fold_idx and ptr hold.
  - When the entry num_folds-1 is issued: go to DRAIN and set drain_cnt = ADD_LAT+1.
  - num_folds=1 goes straight to DRAIN after one issue.
- DRAIN:
  - o_valid=0; add_en/cmd/sel hold the last entry, so the registered adder output stays selected.
  - drain_cnt decrements every cycle regardless of stall.
  - On the edge where drain_cnt==1, go to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE; o_busy is 0 in the following cycle.
- Writes while busy (ISSUE, DRAIN, DONE): ignored, memory unchanged, o_err set.
- i_start while busy: ignored, no error.
- A write and a start on the same IDLE edge: the write takes effect, and the start reads the pre-write contents for that address if it is ptr 0. In other words, the memory read is the old value.
- o_err is sticky until the next accepted start or reset.

Optional Feature:
- Macro: AS_CMD_CHECK_EN.
- With the macro defined:
  - Each write is checked per switch.
  - A write is rejected if cmd is 3'b110 or 3'b111, or if add_en=1 with cmd != 3'b010.
  - A rejected write sets o_err and leaves memory unchanged.
- Without the macro: every IDLE write is stored unchecked; o_err covers only busy-writes and bad num_folds.

Test Plan:
- Basic sequence:
  - Stimulus: write entries 0..2 with distinct patterns (e.g. switch0 cmd=010 add_en=1 sel=01), then start with num_folds=3 and no stall.
  - Response: o_valid=1 for 3 consecutive cycles starting the cycle after start, outputs equal mem[0..2], fold_idx 0,1,2.
  - Response: o_done pulses exactly ADD_LAT+2 cycles after the last valid (with ADD_LAT=1, 3 cycles later).
- Stall:
  - Stimulus: num_folds=4, i_stall=1 for 2 cycles after entry 1.
  - Response: o_valid low for 2 cycles, outputs hold entry 1, then entries 2 and 3 are issued. Total valid count is 4 and no entry is repeated or skipped.
- Illegal start:
  - Stimulus: start with num_folds=0, then with num_folds=17.
  - Response: o_err=1, o_busy stays 0, o_valid never rises.
  - Stimulus: a subsequent legal start. Response: o_err clears.
- Busy write:
  - Stimulus: write addr 1 during ISSUE of a 3-fold run.
  - Response: the run issues the original mem[1], o_err=1.
  - Stimulus: read back by rerunning. Response: entry 1 is unchanged.
- Reset mid-operation:
  - Stimulus: assert rst during DRAIN.
  - Response: all outputs 0 next cycle, no o_done pulse.
  - Stimulus: start again. Response: previously written entries are reissued correctly.
- AS_CMD_CHECK_EN:
  - Stimulus: write cmd=111, and separately add_en=1 with cmd=011.
  - Response with macro: o_err=1, memory unchanged.
  - Response without macro: entries are stored and issued as written.

Source files
------------

// File: rtl/adder_switch_cfg_seq_if.sv
// Bus bundle for the adder-switch configuration sequencer.
// master: the side that writes config, starts runs and applies backpressure.
// slave : the sequencer itself, which drives the adder-switch control outputs.
interface adder_switch_cfg_seq_if #(
    parameter int NUM_AS = 4,
    parameter int SEL_IN = 2,
    parameter int ADDR_W = 4
);
    localparam int ENT_W = NUM_AS * (4 + SEL_IN);

    logic                     i_cfg_wr_en;
    logic [ADDR_W-1:0]        i_cfg_wr_addr;
    logic [ENT_W-1:0]         i_cfg_wr_data;
    logic                     i_start;
    logic [ADDR_W:0]          i_num_folds;
    logic                     i_stall;

    logic                     o_valid;
    logic [NUM_AS-1:0]        o_add_en;
    logic [3*NUM_AS-1:0]      o_cmd;
    logic [SEL_IN*NUM_AS-1:0] o_sel;
    logic [ADDR_W-1:0]        o_fold_idx;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_err;

    modport master (
        output i_cfg_wr_en, i_cfg_wr_addr, i_cfg_wr_data, i_start, i_num_folds, i_stall,
        input  o_valid, o_add_en, o_cmd, o_sel, o_fold_idx, o_busy, o_done, o_err
    );

    modport slave (
        input  i_cfg_wr_en, i_cfg_wr_addr, i_cfg_wr_data, i_start, i_num_folds, i_stall,
        output o_valid, o_add_en, o_cmd, o_sel, o_fold_idx, o_busy, o_done, o_err
    );
endinterface

// File: rtl/adder_switch_cfg_seq.sv
// Configuration sequencer for a row of NUM_AS adder switches.
// A small config memory holds one "fold" per entry; a started run issues
// entries 0..num_folds-1 on unstalled cycles, waits ADD_LAT+1 cycles for the
// adder pipeline to drain and then pulses o_done.
// Optional build macro: AS_CMD_CHECK_EN -- when defined, config writes whose
// per-switch {add_en, cmd} combination is illegal are rejected and flag o_err.
module adder_switch_cfg_seq #(
    parameter int NUM_AS  = 4,
    parameter int SEL_IN  = 2,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                  CLK,
    input  logic                  rst,
    adder_switch_cfg_seq_if.slave bus
);
    localparam int F_W   = 4 + SEL_IN;
    localparam int ENT_W = NUM_AS * F_W;
    localparam int NF_W  = ADDR_W + 1;
    localparam int DRN_W = $clog2(ADD_LAT + 2) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [ENT_W-1:0]         r_mem [DEPTH];
    logic [NF_W-1:0]          r_ptr, w_ptr_nxt;
    logic [NF_W-1:0]          r_num_folds, w_num_nxt;
    logic [NF_W-1:0]          w_issue_ptr;
    logic [DRN_W-1:0]         r_drain, w_drain_nxt;
    logic                     r_valid, w_valid_nxt;
    logic [NUM_AS-1:0]        r_add_en, w_add_en_nxt;
    logic [3*NUM_AS-1:0]      r_cmd, w_cmd_nxt;
    logic [SEL_IN*NUM_AS-1:0] r_sel, w_sel_nxt;
    logic [ADDR_W-1:0]        r_fold_idx, w_fold_idx_nxt;
    logic                     r_busy, w_busy_nxt;
    logic                     r_done, w_done_nxt;
    logic                     r_err, w_err_nxt;
    logic                     w_issue;
    logic                     w_mem_we;
    logic                     w_wr_ok;
    logic                     w_start_ok;
    logic                     w_err_set;
    logic                     w_err_clr;
    logic [ENT_W-1:0]         w_entry;

`ifdef AS_CMD_CHECK_EN
    // An entry is legal when no switch uses a reserved command and add_en is
    // only paired with the add command.
    function automatic logic f_entry_ok(input logic [ENT_W-1:0] e);
        logic       ok;
        logic [2:0] c;
        logic       a;
        ok = 1'b1;
        for (int k = 0; k < NUM_AS; k++) begin
            c = e[k*F_W+SEL_IN +: 3];
            a = e[k*F_W+SEL_IN+3];
            if ((c == 3'b110) || (c == 3'b111)) begin
                ok = 1'b0;
            end else if (a && (c != 3'b010)) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    assign w_wr_ok = f_entry_ok(bus.i_cfg_wr_data);
`else
    assign w_wr_ok = 1'b1;
`endif

    assign w_start_ok = (bus.i_num_folds != {NF_W{1'b0}}) &&
                        (bus.i_num_folds <= NF_W'(DEPTH));

    // Next-state, next-output, memory-write and error-flag decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_num_nxt      = r_num_folds;
        w_drain_nxt    = r_drain;
        w_valid_nxt    = 1'b0;
        w_add_en_nxt   = r_add_en;
        w_cmd_nxt      = r_cmd;
        w_sel_nxt      = r_sel;
        w_fold_idx_nxt = r_fold_idx;
        w_done_nxt     = 1'b0;
        w_issue        = 1'b0;
        w_issue_ptr    = r_ptr;
        w_mem_we       = 1'b0;
        w_err_set      = 1'b0;
        w_err_clr      = 1'b0;
        w_entry        = {ENT_W{1'b0}};

        // Writes land only in IDLE; anything written while a run is in
        // flight is dropped so the sequence being issued cannot change.
        if (bus.i_cfg_wr_en) begin
            if ((r_state == S_IDLE) && w_wr_ok) begin
                w_mem_we = 1'b1;
            end else begin
                w_err_set = 1'b1;
            end
        end else begin
            w_mem_we = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    if (w_start_ok) begin
                        w_num_nxt   = bus.i_num_folds;
                        w_err_clr   = 1'b1;
                        w_state_nxt = S_ISSUE;
                        w_ptr_nxt   = {NF_W{1'b0}};
                        w_issue_ptr = {NF_W{1'b0}};
                        w_issue     = !bus.i_stall;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_issue_ptr = r_ptr;
                w_issue     = !bus.i_stall;
            end
            S_DRAIN: begin
                // Counts down unconditionally: the adder pipeline ignores stall.
                w_drain_nxt = r_drain - DRN_W'(1);
                if (r_drain == DRN_W'(1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Issue one entry; memory read here sees the pre-write contents when
        // a write lands on the same edge.
        if (w_issue) begin
            w_entry        = r_mem[w_issue_ptr[ADDR_W-1:0]];
            w_valid_nxt    = 1'b1;
            w_fold_idx_nxt = w_issue_ptr[ADDR_W-1:0];
            w_ptr_nxt      = w_issue_ptr + NF_W'(1);
            for (int k = 0; k < NUM_AS; k++) begin
                w_add_en_nxt[k]               = w_entry[k*F_W+SEL_IN+3];
                w_cmd_nxt[3*k +: 3]           = w_entry[k*F_W+SEL_IN +: 3];
                w_sel_nxt[SEL_IN*k +: SEL_IN] = w_entry[k*F_W +: SEL_IN];
            end
            if (w_issue_ptr == (w_num_nxt - NF_W'(1))) begin
                w_state_nxt = S_DRAIN;
                w_drain_nxt = DRN_W'(ADD_LAT + 1);
            end else begin
                w_state_nxt = S_ISSUE;
            end
        end else begin
            w_valid_nxt = 1'b0;
        end

        // Busy also covers the done-pulse cycle so it falls the cycle after.
        w_busy_nxt = (w_state_nxt != S_IDLE) || (r_state == S_DONE);

        if (w_err_set) begin
            w_err_nxt = 1'b1;
        end else if (w_err_clr) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= {NF_W{1'b0}};
            r_num_folds <= {NF_W{1'b0}};
            r_drain     <= {DRN_W{1'b0}};
            r_valid     <= 1'b0;
            r_add_en    <= {NUM_AS{1'b0}};
            r_cmd       <= {(3*NUM_AS){1'b0}};
            r_sel       <= {(SEL_IN*NUM_AS){1'b0}};
            r_fold_idx  <= {ADDR_W{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_num_folds <= w_num_nxt;
            r_drain     <= w_drain_nxt;
            r_valid     <= w_valid_nxt;
            r_add_en    <= w_add_en_nxt;
            r_cmd       <= w_cmd_nxt;
            r_sel       <= w_sel_nxt;
            r_fold_idx  <= w_fold_idx_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Config memory write port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (w_mem_we && !rst) begin
            r_mem[bus.i_cfg_wr_addr] <= bus.i_cfg_wr_data;
        end
    end

    assign bus.o_valid    = r_valid;
    assign bus.o_add_en   = r_add_en;
    assign bus.o_cmd      = r_cmd;
    assign bus.o_sel      = r_sel;
    assign bus.o_fold_idx = r_fold_idx;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_err      = r_err;
endmodule

// File: tb/tb_adder_switch_cfg_seq.sv
// Self-checking bench for adder_switch_cfg_seq: a scoreboard of the config
// memory predicts which entry must appear on each valid cycle, when o_done
// must pulse and how o_err must behave.
module tb_adder_switch_cfg_seq;
    localparam int NUM_AS  = 4;
    localparam int SEL_IN  = 2;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int ADD_LAT = 1;
    localparam int F       = 4 + SEL_IN;
    localparam int ENT_W   = NUM_AS * F;

    logic CLK = 1'b0;
    logic rst = 1'b1;

    adder_switch_cfg_seq_if #(.NUM_AS(NUM_AS), .SEL_IN(SEL_IN), .ADDR_W(ADDR_W)) bus ();

    adder_switch_cfg_seq #(
        .NUM_AS(NUM_AS), .SEL_IN(SEL_IN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ADD_LAT(ADD_LAT)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int               errors = 0;
    int               checks = 0;
    logic [ENT_W-1:0] mdl_mem [DEPTH];
    logic             mdl_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Legality of an entry as the optional write checker defines it.
    function automatic bit tb_legal(input logic [ENT_W-1:0] e);
        bit ok;
        ok = 1'b1;
`ifdef AS_CMD_CHECK_EN
        for (int k = 0; k < NUM_AS; k++) begin
            int cmd;
            int ae;
            cmd = int'((e >> (k*F + SEL_IN)) & 7);
            ae  = int'((e >> (k*F + SEL_IN + 3)) & 1);
            if (cmd >= 6 || (ae == 1 && cmd != 2)) ok = 1'b0;
        end
`endif
        return ok;
    endfunction

    function automatic logic [ENT_W-1:0] mk_sw(input int k, input int ae, input int cmd, input int sel,
                                               input logic [ENT_W-1:0] base);
        logic [ENT_W-1:0] e;
        e = base;
        e[k*F +: F] = {ae[0], cmd[2:0], sel[SEL_IN-1:0]};
        return e;
    endfunction

    function automatic logic [ENT_W-1:0] gen_entry();
        logic [ENT_W-1:0] e;
        int cmd;
        e = '0;
        for (int k = 0; k < NUM_AS; k++) begin
            cmd = int'($urandom_range(0, 5));
            e = mk_sw(k, (cmd == 2) ? int'($urandom_range(0, 1)) : 0, cmd, int'($urandom_range(0, 3)), e);
        end
        return e;
    endfunction

    task automatic chk_entry(input string tag, input logic [ENT_W-1:0] e, input int idx);
        logic [NUM_AS-1:0]        ae;
        logic [3*NUM_AS-1:0]      cm;
        logic [SEL_IN*NUM_AS-1:0] sl;
        for (int k = 0; k < NUM_AS; k++) begin
            ae[k]                  = e[k*F+SEL_IN+3];
            cm[3*k +: 3]           = e[k*F+SEL_IN +: 3];
            sl[SEL_IN*k +: SEL_IN] = e[k*F +: SEL_IN];
        end
        chk({tag, "_add_en"}, bus.o_add_en, ae);
        chk({tag, "_cmd"}, bus.o_cmd, cm);
        chk({tag, "_sel"}, bus.o_sel, sl);
        chk({tag, "_idx"}, bus.o_fold_idx, idx);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, bus.o_valid, 64'd0);
        chk({tag, "_add_en"}, bus.o_add_en, 64'd0);
        chk({tag, "_cmd"}, bus.o_cmd, 64'd0);
        chk({tag, "_sel"}, bus.o_sel, 64'd0);
        chk({tag, "_idx"}, bus.o_fold_idx, 64'd0);
        chk({tag, "_busy"}, bus.o_busy, 64'd0);
        chk({tag, "_done"}, bus.o_done, 64'd0);
        chk({tag, "_err"}, bus.o_err, 64'd0);
    endtask

    // IDLE config write; the scoreboard stores it unless the checker rejects it.
    task automatic cfg_write(input int a, input logic [ENT_W-1:0] d);
        bus.i_cfg_wr_en   = 1'b1;
        bus.i_cfg_wr_addr = a[ADDR_W-1:0];
        bus.i_cfg_wr_data = d;
        @(negedge CLK);
        bus.i_cfg_wr_en = 1'b0;
        if (tb_legal(d)) mdl_mem[a] = d;
        else mdl_err = 1'b1;
        chk("wr_err", bus.o_err, mdl_err);
    endtask

    // One run of n folds. spat[k] is i_stall on edge k (edge 0 samples start).
    // wr_cyc 0 writes on the start edge; wr_cyc>0 writes while busy.
    task automatic run(input int n, input logic [63:0] spat, input int wr_cyc,
                       input int wr_a, input logic [ENT_W-1:0] wr_d);
        int               pos;
        int               last;
        bit               fin;
        logic             s_prev;
        logic             wr_prev;
        logic             exp_v;
        logic [ENT_W-1:0] held;
        pos = 0; last = -100; fin = 1'b0; wr_prev = 1'b0; held = '0;
        s_prev            = spat[0];
        bus.i_start       = 1'b1;
        bus.i_num_folds   = n[ADDR_W:0];
        bus.i_stall       = s_prev;
        bus.i_cfg_wr_en   = (wr_cyc == 0);
        bus.i_cfg_wr_addr = wr_a[ADDR_W-1:0];
        bus.i_cfg_wr_data = wr_d;
        mdl_err           = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            @(negedge CLK);
            bus.i_start = 1'b0;
            if (wr_prev) mdl_err = 1'b1;
            exp_v = !s_prev && (pos < n);
            chk("valid", bus.o_valid, exp_v);
            if (exp_v) begin
                chk_entry("issue", mdl_mem[pos], pos);
                held = mdl_mem[pos];
                pos++;
                if (pos == n) last = cyc;
            end else if (pos > 0) begin
                chk_entry("hold", held, pos - 1);
            end
            chk("done", bus.o_done, cyc == last + ADD_LAT + 2);
            chk("busy", bus.o_busy, (pos < n) || (cyc <= last + ADD_LAT + 2));
            chk("err", bus.o_err, mdl_err);
            if (cyc == last + ADD_LAT + 2) begin
                fin = 1'b1;
                break;
            end
            s_prev          = (cyc < 64) ? spat[cyc] : 1'b0;
            bus.i_stall     = s_prev;
            bus.i_cfg_wr_en = (cyc == wr_cyc);
            wr_prev         = (cyc == wr_cyc);
        end
        bus.i_stall     = 1'b0;
        bus.i_cfg_wr_en = 1'b0;
        chk("run_finished", fin, 64'd1);
        chk("valid_count", pos, n);
        if (wr_cyc == 0 && tb_legal(wr_d)) mdl_mem[wr_a] = wr_d;
        @(negedge CLK);
        chk("post_done", bus.o_done, 64'd0);
        chk("post_busy", bus.o_busy, 64'd0);
    endtask

    task automatic bad_start(input int n);
        bus.i_start     = 1'b1;
        bus.i_num_folds = n[ADDR_W:0];
        @(negedge CLK);
        bus.i_start = 1'b0;
        mdl_err     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bad_err", bus.o_err, mdl_err);
            chk("bad_busy", bus.o_busy, 64'd0);
            chk("bad_valid", bus.o_valid, 64'd0);
            @(negedge CLK);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ENT_W-1:0] e;
        logic [63:0]      sp;
        bus.i_cfg_wr_en   = 1'b0;
        bus.i_cfg_wr_addr = '0;
        bus.i_cfg_wr_data = '0;
        bus.i_start       = 1'b0;
        bus.i_num_folds   = '0;
        bus.i_stall       = 1'b0;
        rst               = 1'b1;
        repeat (2) @(negedge CLK);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge CLK);

        // Distinct directed patterns for entries 0..2, random legal elsewhere.
        e = mk_sw(0, 1, 2, 1, '0);
        e = mk_sw(1, 0, 1, 2, e);
        cfg_write(0, e);
        cfg_write(1, mk_sw(2, 1, 2, 3, mk_sw(0, 0, 4, 2, '0)));
        cfg_write(2, mk_sw(3, 0, 5, 1, mk_sw(1, 1, 2, 0, '0)));
        for (int a = 3; a < DEPTH; a++) cfg_write(a, gen_entry());

        // Basic three-fold run, no stall.
        run(3, 64'd0, -1, 0, '0);
        // Stall for two cycles right after entry 1.
        run(4, 64'b1100, -1, 0, '0);
        // Single fold, with a stalled start edge.
        run(1, 64'b1, -1, 0, '0);
        // Full depth.
        run(16, 64'd0, -1, 0, '0);

        // Illegal fold counts, then a legal start must clear o_err.
        bad_start(0);
        bad_start(17);
        run(2, 64'd0, -1, 0, '0);

        // Write during ISSUE is dropped and flags o_err; rerun confirms entry 1.
        run(3, 64'd0, 1, 1, gen_entry());
        run(3, 64'd0, -1, 0, '0);

        // Write and start on the same edge: fold 0 must be the old entry.
        run(1, 64'd0, 0, 0, gen_entry());
        run(1, 64'd0, -1, 0, '0);

        // Reset during DRAIN aborts the run without a done pulse.
        bus.i_start     = 1'b1;
        bus.i_num_folds = 5'd2;
        @(negedge CLK);
        bus.i_start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("drain_valid", bus.o_valid, 64'd0);
        chk("drain_busy", bus.o_busy, 64'd1);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        mdl_err = 1'b0;
        chk_zero("midreset");
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("abort_done", bus.o_done, 64'd0);
            chk("abort_busy", bus.o_busy, 64'd0);
        end
        run(5, 64'd0, -1, 0, '0);

        // Entries that the optional checker considers illegal.
        cfg_write(5, mk_sw(1, 0, 7, 2, gen_entry()));
        cfg_write(6, mk_sw(2, 1, 3, 1, gen_entry()));
        run(8, 64'd0, -1, 0, '0);

        // Randomized runs with random stalls and fresh entries.
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 3; w++) cfg_write(int'($urandom_range(0, DEPTH - 1)), gen_entry());
            sp = {$urandom, $urandom} & {$urandom, $urandom};
            run(int'($urandom_range(1, DEPTH)), sp, -1, 0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
